// File: rtl/tt_extract_pkg.sv
// Shared types and helpers for the truth-table extractor.
// Helpers take a zero-extended table so they serve any N_IN up to 6.
package tt_extract_pkg;

    localparam int N_IN_DEF = 4;
    localparam int TT_W     = 2**N_IN_DEF;
    localparam int TT_MAX_W = 64;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    function automatic int unsigned popcount_tt(input logic [TT_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < TT_MAX_W; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Returns 0 when no bit is set, so a matching table reports first_err = 0.
    function automatic int lowest_set_idx(input logic [TT_MAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = TT_MAX_W - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tt_lat_pipe.sv
// Delay line carrying the {valid, idx} sample tag alongside the network latency.
// Depth 0 degenerates to a wire so combinational networks sample in the drive cycle.
module tt_lat_pipe #(
    parameter int LAT = 0,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] idx,
    output logic         tag_valid,
    output logic [W-1:0] tag_idx
);

    if (LAT == 0) begin : g_wire
        logic unused;
        assign unused    = clk ^ rst;
        assign tag_valid = valid;
        assign tag_idx   = idx;
    end else begin : g_pipe
        logic [LAT-1:0] vld_p;
        logic [W-1:0]   idx_p [LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= '0;
                for (int i = 0; i < LAT; i++) idx_p[i] <= '0;
            end else begin
                vld_p[0] <= valid;
                idx_p[0] <= idx;
                for (int i = 1; i < LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                    idx_p[i] <= idx_p[i-1];
                end
            end
        end

        assign tag_valid = vld_p[LAT-1];
        assign tag_idx   = idx_p[LAT-1];
    end

endmodule

// File: rtl/tt_extract.sv
// Sweeps every minterm onto a single-output network, assembles its truth table
// and compares it against an expected table captured at start.
module tt_extract #(
    parameter int N_IN = 4,
    parameter int TT_W = 2**N_IN,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] exp_tt,
    output logic [N_IN-1:0] x,
    input  logic            y,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic [N_IN:0]   ones,
    output logic            match,
    output logic [N_IN-1:0] first_err
);

    import tt_extract_pkg::*;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [2:0]      drain_cnt;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] tt_nxt;
    logic [TT_W-1:0] diff;
    logic            drive_vld;
    logic            drive_last;
    logic            sweep_end;
    logic            tag_valid;
    logic [N_IN-1:0] tag_idx;

    assign drive_vld  = (state == DRIVE);
    assign drive_last = (idx == N_IN'(TT_W - 1));
    assign sweep_end  = (drive_vld && drive_last && (LAT == 0)) ||
                        ((state == DRAIN) && (drain_cnt == 3'(LAT - 1)));

    tt_lat_pipe #(.LAT(LAT), .W(N_IN)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid     (drive_vld),
        .idx       (idx),
        .tag_valid (tag_valid),
        .tag_idx   (tag_idx)
    );

    // Results are registered from the table including the final sample, so they
    // are valid in the same cycle as done.
    always_comb begin
        tt_nxt = tt;
        if (tag_valid) tt_nxt[tag_idx] = y;
    end

    assign diff = tt_nxt ^ exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            x         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt        <= '0;
            ones      <= '0;
            match     <= 1'b0;
            first_err <= '0;
        end else begin
            done <= 1'b0;
            tt   <= tt_nxt;
            case (state)
                IDLE: begin
                    x <= '0;
                    if (start) begin
                        exp_q <= exp_tt;
                        tt    <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    idx <= idx + 1'b1;
                    if (!drive_last) begin
                        x <= idx + 1'b1;
                    end else if (LAT > 0) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (sweep_end) begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                x         <= '0;
                match     <= (tt_nxt == exp_q);
                ones      <= (N_IN+1)'(popcount_tt(TT_MAX_W'(tt_nxt)));
                first_err <= N_IN'(lowest_set_idx(TT_MAX_W'(diff)));
            end
        end
    end

endmodule

// File: tb/tb_tt_extract.sv
// Directed bench for tt_extract: a combinational network at LAT=0 and a
// three-register network at LAT=3, with hand-computed expected tables.
module tb_tt_extract;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] ex = '0;

    logic        start0, start1, y0, y1;
    logic [3:0]  x0, x1, fe0, fe1;
    logic        busy0, busy1, done0, done1, match0, match1;
    logic [15:0] tt0, tt1;
    logic [4:0]  ones0, ones1;
    logic [2:0]  sr = '0;

    logic [3:0]  x_s, fe_s;
    logic        busy_s, done_s, match_s;
    logic [15:0] tt_s;
    logic [4:0]  ones_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    always_comb begin
        case (mode)
            2'd0:    y0 = x0[0] & x0[1];
            2'd1:    y0 = ^x0;
            2'd2:    y0 = 1'b1;
            default: y0 = 1'b0;
        endcase
    end

    always_ff @(posedge clk) sr <= {sr[1:0], x1[3]};
    assign y1 = sr[2];

    assign x_s     = sel ? x1 : x0;
    assign busy_s  = sel ? busy1 : busy0;
    assign done_s  = sel ? done1 : done0;
    assign tt_s    = sel ? tt1 : tt0;
    assign ones_s  = sel ? ones1 : ones0;
    assign match_s = sel ? match1 : match0;
    assign fe_s    = sel ? fe1 : fe0;

    tt_extract #(.N_IN(4), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .exp_tt(ex), .x(x0), .y(y0),
        .busy(busy0), .done(done0), .tt(tt0), .ones(ones0), .match(match0),
        .first_err(fe0)
    );

    tt_extract #(.N_IN(4), .LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .exp_tt(ex), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .tt(tt1), .ones(ones1), .match(match1),
        .first_err(fe1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Accepts one sweep and captures the outputs in the done cycle.
    task automatic sweep(input logic [15:0] e, input bit pulses,
                         output int done_at, output int busy_cnt,
                         output logic [15:0] r_tt, output logic [4:0] r_ones,
                         output logic r_match, output logic [3:0] r_fe);
        ex = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1;
        busy_cnt = 0;
        r_tt = 'x; r_ones = 'x; r_match = 1'bx; r_fe = 'x;
        for (int n = 1; n <= 60; n++) begin
            if (busy_s) busy_cnt++;
            if (done_s) begin
                done_at = n;
                r_tt = tt_s; r_ones = ones_s; r_match = match_s; r_fe = fe_s;
                break;
            end
            if (pulses && n == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (pulses) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end else begin
            tick();
        end
    endtask

    initial begin
        int d_at, b_cnt, dn_cnt;
        logic [15:0] r_tt;
        logic [4:0]  r_ones;
        logic        r_match;
        logic [3:0]  r_fe;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_x", 32'(x0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_tt", 32'(tt0), 32'h0);
        chk("rst_ones", 32'(ones0), 32'h0);
        chk("rst_match", 32'(match0), 32'h0);
        chk("rst_fe", 32'(fe0), 32'h0);
        chk("rst_tt_lat3", 32'(tt1), 32'h0);
        rst = 1'b0;
        tick();

        // AND2 network, LAT=0
        mode = 2'd0;
        sweep(16'h8888, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("and_done_at", 32'(d_at), 32'd17);
        chk("and_busy_cycles", 32'(b_cnt), 32'd16);
        chk("and_tt", 32'(r_tt), 32'h8888);
        chk("and_ones", 32'(r_ones), 32'd4);
        chk("and_match", 32'(r_match), 32'd1);
        chk("and_fe", 32'(r_fe), 32'd0);
        chk("and_tt_hold", 32'(tt0), 32'h8888);
        chk("and_done_low", 32'(done0), 32'd0);

        // XOR4 network
        mode = 2'd1;
        sweep(16'h6996, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("xor_tt", 32'(r_tt), 32'h6996);
        chk("xor_ones", 32'(r_ones), 32'd8);
        chk("xor_match", 32'(r_match), 32'd1);
        sweep(16'h6997, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("xor_bad_match", 32'(r_match), 32'd0);
        chk("xor_bad_fe", 32'(r_fe), 32'd0);

        // Three-cycle registered x3, LAT=3
        sel = 1'b1;
        sweep(16'hFF00, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("lat3_done_at", 32'(d_at), 32'd20);
        chk("lat3_busy_cycles", 32'(b_cnt), 32'd19);
        chk("lat3_tt", 32'(r_tt), 32'hFF00);
        chk("lat3_ones", 32'(r_ones), 32'd8);
        chk("lat3_match", 32'(r_match), 32'd1);
        sel = 1'b0;

        // Constant networks
        mode = 2'd2;
        sweep(16'h8880, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("one_tt", 32'(r_tt), 32'hFFFF);
        chk("one_ones", 32'(r_ones), 32'd16);
        chk("one_match", 32'(r_match), 32'd0);
        chk("one_fe", 32'(r_fe), 32'd0);
        mode = 2'd3;
        sweep(16'h0010, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("zero_tt", 32'(r_tt), 32'h0000);
        chk("zero_ones", 32'(r_ones), 32'd0);
        chk("zero_match", 32'(r_match), 32'd0);
        chk("zero_fe", 32'(r_fe), 32'd4);

        // Extra start pulses mid-sweep and in the DONE cycle are ignored
        mode = 2'd0;
        sweep(16'h8888, 1'b1, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("pulse_done_at", 32'(d_at), 32'd17);
        chk("pulse_tt", 32'(r_tt), 32'h8888);
        dn_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done0) dn_cnt++;
            if (busy0) b_cnt++;
            tick();
        end
        chk("pulse_extra_done", 32'(dn_cnt), 32'd0);
        chk("pulse_extra_busy", 32'(b_cnt), 32'd0);
        chk("pulse_tt_hold", 32'(tt0), 32'h8888);
        chk("pulse_match_hold", 32'(match0), 32'd1);

        // Reset in the middle of a constant-1 sweep
        mode = 2'd2;
        ex = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 8; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_x", 32'(x0), 32'h0);
        chk("abort_busy", 32'(busy0), 32'h0);
        chk("abort_done", 32'(done0), 32'h0);
        chk("abort_tt", 32'(tt0), 32'h0);
        chk("abort_ones", 32'(ones0), 32'h0);
        chk("abort_match", 32'(match0), 32'h0);
        chk("abort_fe", 32'(fe0), 32'h0);
        tick();
        mode = 2'd0;
        sweep(16'h8888, 1'b0, d_at, b_cnt, r_tt, r_ones, r_match, r_fe);
        chk("fresh_done_at", 32'(d_at), 32'd17);
        chk("fresh_tt", 32'(r_tt), 32'h8888);
        chk("fresh_ones", 32'(r_ones), 32'd4);
        chk("fresh_match", 32'(r_match), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
